// File: rtl/gray_frame_loader.sv
// Gray frame loader: RGB888 stream -> 8-bit luma writes into the Sobel input image memory.
// Optional macro GRAY_LOADER_BYPASS_EN adds bypass_i to store R unmodified for pre-converted sources.
module gray_frame_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_ROWS   = 4,
  parameter int IMG_COLS   = 4,
  parameter int ADDR_WIDTH = $clog2(IMG_ROWS * IMG_COLS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef GRAY_LOADER_BYPASS_EN
  input  logic                  bypass_i,
`endif
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [23:0]           s_rgb_i,
  input  logic                  s_last_i,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  sobel_start_o,
  input  logic                  sobel_finish_i,
  output logic                  frame_err_o
);

  localparam int FRAME = IMG_ROWS * IMG_COLS;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DRAIN,
    ST_START,
    ST_WAIT
  } state_e;

  state_e                  state_q;
  logic                    ready_q;
  logic                    start_q;
  logic                    err_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    s1_valid_q;
  logic [ADDR_WIDTH-1:0]   s1_addr_q;
  logic [DATA_WIDTH-1:0]   s1_data_q;
  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;

  logic                    accept;
  logic                    is_last_idx;
  logic [15:0]             y_sum;
  logic [DATA_WIDTH-1:0]   pix_d;

  assign accept      = s_valid_i & ready_q;
  assign is_last_idx = (cnt_q == LAST_IDX);

  // Rounded fixed-point BT.601 luma; the maximum sum 65408 fits the 16-bit accumulator.
  assign y_sum = 16'd77  * {8'd0, s_rgb_i[23:16]}
               + 16'd150 * {8'd0, s_rgb_i[15:8]}
               + 16'd29  * {8'd0, s_rgb_i[7:0]}
               + 16'd128;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pix_d = DATA_WIDTH'(y_sum >> 8);
`ifdef GRAY_LOADER_BYPASS_EN
    if (bypass_i) pix_d = DATA_WIDTH'(s_rgb_i[23:16]);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_LOAD;
      ready_q    <= 1'b0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      wr_en_q    <= s1_valid_q;
      start_q    <= 1'b0;
      if (s1_valid_q) begin
        wr_addr_q <= s1_addr_q;
        wr_data_q <= s1_data_q;
      end
      if (accept) begin
        s1_addr_q <= cnt_q;
        s1_data_q <= pix_d;
        if (s_last_i != is_last_idx) err_q <= 1'b1;
        // The counter parks on the final index; only leaving WAIT rewinds it.
        if (!is_last_idx) cnt_q <= cnt_q + 1'b1;
      end
      case (state_q)
        ST_LOAD: begin
          if (accept && is_last_idx) begin
            ready_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_DRAIN: if (s1_valid_q) state_q <= ST_START;
        ST_START: begin
          start_q <= 1'b1;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sobel_finish_i) begin
            cnt_q   <= '0;
            ready_q <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign s_ready_o     = ready_q;
  assign mem_wr_en_o   = wr_en_q;
  assign mem_addr_o    = wr_addr_q;
  assign mem_data_o    = wr_data_q;
  assign sobel_start_o = start_q;
  assign frame_err_o   = err_q;

endmodule
